// File: rtl/handler_stream_arbiter_if.sv
// Bundle of the per-source AM handler streams and the merged axis_handler stream.
// slave is the arbiter's view; master is the view of the sources plus the downstream sink.
interface handler_stream_arbiter_if #(
   parameter int NUM_SOURCES = 4
);
   logic [64*NUM_SOURCES-1:0] s_axis_tdata;
   logic [NUM_SOURCES-1:0]    s_axis_tlast;
   logic [NUM_SOURCES-1:0]    s_axis_tvalid;
   logic [NUM_SOURCES-1:0]    s_axis_tready;
   logic [63:0]               m_axis_tdata;
   logic                      m_axis_tlast;
   logic                      m_axis_tvalid;
   logic                      m_axis_tready;

   modport slave (
      input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid
   );

   modport master (
      output s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid
   );
endinterface

// File: rtl/handler_stream_arbiter.sv
// Packet-atomic round-robin merge of AM handler streams into one handler stream.
// Packets whose header dest ID falls outside the kernel range are drained and counted.
module handler_stream_arbiter #(
   parameter int  NUM_SOURCES = 4,
   parameter int  NUM_KERNELS = 2,
   parameter int  CNT_WIDTH   = 16,
   localparam int SW          = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   handler_stream_arbiter_if.slave axis,
   input  logic [15:0]          address_offset,
   output logic                 busy,
   output logic [SW-1:0]        grant,
   output logic [CNT_WIDTH-1:0] drop_count
);
   typedef enum logic [1:0] {ST_ARB, ST_PASS, ST_DROP} state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        grant_q, grant_d;
   logic [CNT_WIDTH-1:0] drop_q, drop_d;

   logic [63:0]   src_data [NUM_SOURCES];
   logic          win_found;
   logic [SW-1:0] win_idx;
   logic [15:0]   win_dest;
   logic          win_in_range;

   for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_unpack
      assign src_data[gi] = axis.s_axis_tdata[64*gi +: 64];
   end

   // Scan from the farthest candidate back to grant+1 so the nearest valid source wins.
   always_comb begin
      logic [SW-1:0] cand;
      win_found = 1'b0;
      win_idx   = grant_q;
      cand      = grant_q;
      for (int k = NUM_SOURCES; k >= 1; k--) begin
         cand = SW'((int'(grant_q) + k) % NUM_SOURCES);
         if (axis.s_axis_tvalid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_dest     = src_data[win_idx][39:24] - address_offset;
   assign win_in_range = (win_dest < 16'(NUM_KERNELS));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_ARB;
         grant_q <= SW'(NUM_SOURCES - 1);
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      drop_d  = drop_q;
      case (state_q)
         ST_ARB: begin
            if (win_found) begin
               grant_d = win_idx;
               if (win_in_range) begin
                  state_d = ST_PASS;
               end else begin
                  state_d = ST_DROP;
                  if (drop_q != {CNT_WIDTH{1'b1}}) drop_d = drop_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_PASS: begin
            if (axis.s_axis_tvalid[grant_q] && axis.m_axis_tready && axis.s_axis_tlast[grant_q])
               state_d = ST_ARB;
         end
         ST_DROP: begin
            if (axis.s_axis_tvalid[grant_q] && axis.s_axis_tlast[grant_q])
               state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase
   end

   // Data and last always follow the granted source; only valid/ready depend on state.
   always_comb begin
      axis.m_axis_tdata  = src_data[grant_q];
      axis.m_axis_tlast  = axis.s_axis_tlast[grant_q];
      axis.m_axis_tvalid = 1'b0;
      axis.s_axis_tready = '0;
      busy               = 1'b0;
      case (state_q)
         ST_PASS: begin
            axis.m_axis_tvalid          = axis.s_axis_tvalid[grant_q];
            axis.s_axis_tready[grant_q] = axis.m_axis_tready;
            busy                        = 1'b1;
         end
         ST_DROP: begin
            axis.s_axis_tready[grant_q] = 1'b1;
            busy                        = 1'b1;
         end
         default: ;
      endcase
   end

   assign grant      = grant_q;
   assign drop_count = drop_q;
endmodule

// File: tb/tb_handler_stream_arbiter.sv
// Self-checking bench: queued source packets, a packet-level reference model and scoreboard,
// directed scenarios followed by randomized traffic.
module tb_handler_stream_arbiter;
   localparam int NS   = 4;
   localparam int NK   = 2;
   localparam int CW   = 8;
   localparam int SW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [15:0]   offset;
   logic          busy;
   logic [SW-1:0] grant;
   logic [CW-1:0] drop_count;

   handler_stream_arbiter_if #(.NUM_SOURCES(NS)) bus ();

   handler_stream_arbiter #(
      .NUM_SOURCES(NS), .NUM_KERNELS(NK), .CNT_WIDTH(CW)
   ) dut (
      .clock(clk), .reset_n(reset_n), .axis(bus), .address_offset(offset),
      .busy(busy), .grant(grant), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   logic [64:0] src_q [NS][$];
   logic [64:0] exp_q [NS][$];
   bit          pres [NS];
   int          order_q [$];
   int n_cmp = 0, n_fail = 0;
   int mstate, mgrant, mdrops, gen_drops;
   int rdy_mode = 0, vprob = 100, rprob = 100, cyc = 0, out_beats = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic push_pkt(int s, int len, logic [15:0] dest);
      logic [15:0] rel;
      rel = dest - offset;
      for (int b = 0; b < len; b++) begin
         logic [63:0] dd;
         logic [64:0] beat;
         dd = {$urandom, $urandom};
         if (b == 0) dd[39:24] = dest;
         beat = {(b == len - 1), dd};
         src_q[s].push_back(beat);
         if (rel < 16'(NK)) exp_q[s].push_back(beat);
      end
      if (rel >= 16'(NK) && gen_drops < CMAX) gen_drops++;
   endtask

   task automatic step();
      logic [NS-1:0] v, l, exp_sr;
      logic [63:0]   d [NS];
      logic          mr, exp_mv;
      logic [15:0]   dst;
      int            w;
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         if (!pres[i] && src_q[i].size() > 0 && $urandom_range(99) < vprob) pres[i] = 1'b1;
         v[i] = pres[i];
         d[i] = 64'h0;
         l[i] = 1'b0;
         if (pres[i]) begin
            d[i] = src_q[i][0][63:0];
            l[i] = src_q[i][0][64];
         end
         bus.s_axis_tdata[64*i +: 64] = d[i];
      end
      case (rdy_mode)
         0:       mr = 1'b1;
         1:       mr = ($urandom_range(99) < rprob);
         default: mr = cyc[0];
      endcase
      bus.s_axis_tvalid = v;
      bus.s_axis_tlast  = l;
      bus.m_axis_tready = mr;
      cyc++;
      #1;
      exp_sr = '0;
      exp_mv = 1'b0;
      if (mstate == 1) begin
         exp_mv = v[mgrant];
         exp_sr[mgrant] = mr;
      end else if (mstate == 2) begin
         exp_sr[mgrant] = 1'b1;
      end
      chk("m_tvalid", 64'(bus.m_axis_tvalid), 64'(exp_mv));
      chk("s_tready", 64'(bus.s_axis_tready), 64'(exp_sr));
      chk("busy", 64'(busy), 64'(mstate != 0));
      chk("grant", 64'(grant), 64'(mgrant));
      chk("drop_count", 64'(drop_count), 64'(mdrops));
      chk("m_tdata", bus.m_axis_tdata, d[mgrant]);
      chk("m_tlast", 64'(bus.m_axis_tlast), 64'(l[mgrant]));
      if (bus.m_axis_tvalid && mr) begin
         out_beats++;
         if (exp_q[mgrant].size() == 0) begin
            chk("sb_unexpected_beat", 64'(1), 64'(0));
         end else begin
            logic [64:0] e;
            e = exp_q[mgrant].pop_front();
            chk("sb_data", bus.m_axis_tdata, e[63:0]);
            chk("sb_last", 64'(bus.m_axis_tlast), 64'(e[64]));
         end
         if (bus.m_axis_tlast) order_q.push_back(int'(grant));
      end
      for (int i = 0; i < NS; i++)
         if (v[i] && bus.s_axis_tready[i]) begin
            void'(src_q[i].pop_front());
            pres[i] = 1'b0;
         end
      case (mstate)
         0: begin
            w = -1;
            for (int k = 1; k <= NS && w < 0; k++)
               if (v[(mgrant + k) % NS]) w = (mgrant + k) % NS;
            if (w >= 0) begin
               mgrant = w;
               dst = d[w][39:24] - offset;
               if (dst < 16'(NK)) mstate = 1;
               else begin
                  mstate = 2;
                  if (mdrops < CMAX) mdrops++;
               end
            end
         end
         1: if (v[mgrant] && mr && l[mgrant]) mstate = 0;
         default: if (v[mgrant] && l[mgrant]) mstate = 0;
      endcase
   endtask

   task automatic wait_idle(int budget, output int n);
      bit idle;
      n = 0;
      while (1) begin
         idle = (mstate == 0);
         for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) idle = 1'b0;
         if (idle) break;
         if (n >= budget) begin
            chk("idle_timeout", 64'(n), 64'(budget + 1));
            break;
         end
         step();
         n++;
      end
   endtask

   task automatic do_reset(logic [15:0] off);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      offset  = off;
      for (int i = 0; i < NS; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
         pres[i] = 1'b0;
      end
      bus.s_axis_tvalid = '0;
      bus.s_axis_tlast  = '0;
      bus.s_axis_tdata  = '0;
      bus.m_axis_tready = 1'b0;
      mstate = 0; mgrant = NS - 1; mdrops = 0; gen_drops = 0;
      order_q.delete();
      #1;
      chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
      chk("rst_s_tready", 64'(bus.s_axis_tready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_grant", 64'(grant), 64'(3));
      chk("rst_drop_count", 64'(drop_count), 64'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int n, ob;
      int exp_order [5] = '{0, 1, 2, 3, 0};
      reset_n = 1'b0;
      offset  = 16'h0100;

      // T1: one in-range 3-beat packet
      do_reset(16'h0100);
      rdy_mode = 0; vprob = 100;
      ob = out_beats;
      push_pkt(0, 3, 16'h0101);
      wait_idle(50, n);
      chk("t1_cycles", 64'(n), 64'(4));
      chk("t1_beats", 64'(out_beats - ob), 64'(3));
      chk("t1_grant", 64'(grant), 64'(0));

      // T2: all sources compete, round-robin order from reset
      do_reset(16'h0100);
      for (int s = 0; s < NS; s++) push_pkt(s, 2, 16'h0100);
      push_pkt(0, 2, 16'h0101);
      wait_idle(100, n);
      chk("t2_cycles", 64'(n), 64'(15));
      chk("t2_npkts", 64'(order_q.size()), 64'(5));
      for (int j = 0; j < 5 && j < order_q.size(); j++)
         chk($sformatf("t2_order%0d", j), 64'(order_q[j]), 64'(exp_order[j]));

      // T3: out-of-range packet drained
      do_reset(16'h0100);
      ob = out_beats;
      push_pkt(1, 3, 16'h0102);
      wait_idle(50, n);
      chk("t3_cycles", 64'(n), 64'(4));
      chk("t3_beats", 64'(out_beats - ob), 64'(0));
      chk("t3_drop_count", 64'(drop_count), 64'(1));

      // T4: downstream ready toggles during the packet
      rdy_mode = 2;
      ob = out_beats;
      push_pkt(0, 4, 16'h0100);
      wait_idle(50, n);
      chk("t4_beats", 64'(out_beats - ob), 64'(4));
      chk("t4_sb_empty", 64'(exp_q[0].size()), 64'(0));

      // T5: reset while passing a packet, then source 0 wins first
      rdy_mode = 0;
      do_reset(16'h0100);
      push_pkt(0, 6, 16'h0100);
      repeat (3) step();
      chk("t5_busy_before", 64'(busy), 64'(1));
      do_reset(16'h0100);
      push_pkt(3, 1, 16'h0101);
      push_pkt(0, 1, 16'h0100);
      wait_idle(50, n);
      chk("t5_npkts", 64'(order_q.size()), 64'(2));
      if (order_q.size() == 2) begin
         chk("t5_first", 64'(order_q[0]), 64'(0));
         chk("t5_second", 64'(order_q[1]), 64'(3));
      end

      // T6: drop counter saturates
      do_reset(16'h0100);
      for (int j = 0; j < CMAX; j++) push_pkt($urandom_range(NS - 1), 1, 16'h0105);
      wait_idle(2000, n);
      chk("t6_at_max", 64'(drop_count), 64'(8'hFF));
      push_pkt(2, 1, 16'h0000);
      wait_idle(50, n);
      chk("t6_saturated", 64'(drop_count), 64'(8'hFF));

      // Random traffic with a wrapping offset
      do_reset(16'hFFFF);
      vprob = 70; rdy_mode = 1; rprob = 70;
      for (int j = 0; j < 150; j++)
         push_pkt($urandom_range(NS - 1), $urandom_range(4, 1), 16'hFFFF + 16'($urandom_range(3)));
      wait_idle(5000, n);
      chk("rnd_drop_count", 64'(drop_count), 64'(gen_drops));
      for (int s = 0; s < NS; s++)
         chk($sformatf("rnd_sb_empty%0d", s), 64'(exp_q[s].size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
